axi2apb_bridge_core: RTL and testbench
======================================

Name: axi2apb_bridge_core

Overview:
Synthesizable AXI slave-to-APB3 master bridge. It accepts AXI read and write bursts from the slave-side pins driven by the AXI VIP interface and converts each beat into one APB transfer. It returns B and R responses built from the APB PREADY, PRDATA and PSLVERR signals. Only one AXI transaction is in flight at a time, and all bursts are INCR.

Parameters:
ADDR_W, 32, AXI and APB address width
DATA_W, 32, AXI and APB data width; byte lanes = DATA_W/8
ID_W, 5, AXI ID width

Ports:
AXI_ACLK  in  1  single clock for the AXI and APB sides
AXI_ARESET_N  in  1  asynchronous active-low reset
AXI_AWID  in  ID_W  write ID
AXI_AWADDR  in  ADDR_W  write start address
AXI_AWLEN  in  4  write beats minus 1
AXI_AWVALID  in  1  write address valid
AXI_AWREADY  out  1  write address ready
AXI_WDATA  in  DATA_W  write data
AXI_WSTRB  in  DATA_W/8  write byte strobes
AXI_WVALID  in  1  write data valid
AXI_WREADY  out  1  write data ready
AXI_BID  out  ID_W  response ID
AXI_BRESP  out  2  write response
AXI_BVALID  out  1  write response valid
AXI_BREADY  in  1  write response ready
AXI_ARID  in  ID_W  read ID
AXI_ARADDR  in  ADDR_W  read start address
AXI_ARLEN  in  4  read beats minus 1
AXI_ARVALID  in  1  read address valid
AXI_ARREADY  out  1  read address ready
AXI_RID  out  ID_W  read ID
AXI_RDATA  out  DATA_W  read data
AXI_RRESP  out  2  read response
AXI_RLAST  out  1  last read beat
AXI_RVALID  out  1  read data valid
AXI_RREADY  in  1  read data ready
PADDR  out  ADDR_W  APB address
PWRITE  out  1  APB direction
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWDATA  out  DATA_W  APB write data
PSTRB  out  DATA_W/8  APB strobes
PRDATA  in  DATA_W  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- Reset: asynchronous and active-low. While reset is asserted, all outputs are 0, state = IDLE, beat counter = 0, error flag = 0, priority = write. Reset asserted mid-transaction aborts immediately; no response is issued.
- States: IDLE, W_WAIT, W_SETUP, W_ACCESS, B_RESP, R_SETUP, R_ACCESS, R_DATA.
- IDLE:
  - AWREADY = grant_w and ARREADY = grant_r, both combinational.
  - With only one valid, that channel is granted. With both valid, the channel opposite to the last completed transaction is granted (round-robin).
  - On handshake, register ID, address, LEN; set cnt = 0, err = 0.
  - Next state: W_WAIT for a write, R_SETUP for a read.
- W_WAIT:
  - WREADY = 1.
  - On WVALID, capture WDATA into PWDATA and WSTRB into PSTRB, then go to W_SETUP.
  - WLAST is not used; beat count comes from the registered LEN.
- W_SETUP / R_SETUP: PSEL = 1, PENABLE = 0, PWRITE = 1 for write or 0 for read, PADDR = current address. Always advances to ACCESS after exactly 1 cycle.
- W_ACCESS / R_ACCESS:
  - PSEL = 1, PENABLE = 1; hold all APB outputs until PREADY = 1 (wait states are unbounded).
  - On PREADY: err |= PSLVERR, then PSEL = 0 and PENABLE = 0.
- W_ACCESS exit: if cnt == LEN go to B_RESP; else cnt++, address += DATA_W/8, go to W_WAIT.
- B_RESP:
  - BVALID = 1, BID = registered ID, BRESP = 2'b10 if err else 2'b00.
  - BRESP is sticky over the whole burst.
  - On BREADY: go to IDLE, record last = write.
- R_ACCESS exit: on PREADY, register RDATA = PRDATA, RRESP = PSLVERR ? 2'b10 : 2'b00 (per beat), RLAST = (cnt == LEN), then go to R_DATA.
- R_DATA:
  - RVALID = 1, RID = registered ID; outputs held stable until RREADY.
  - On RREADY: if RLAST, go to IDLE and record last = read; else cnt++, address += DATA_W/8, go to R_SETUP.
- PSTRB = 0 for reads.
- Address arithmetic: address increments modulo 2^ADDR_W with no 4KB boundary check. Addresses are passed through unaligned.
- Latency with PREADY tied high:
  - Single write: AW handshake at cycle 0, W handshake at cycle 1, SETUP at cycle 2, ACCESS at cycle 3, BVALID at cycle 4.
  - Single read: AR handshake at cycle 0, SETUP at cycle 1, ACCESS at cycle 2, RVALID at cycle 3.
- AWREADY and ARREADY stay 0 outside IDLE.

Test Plan:
- Write AWADDR=0x100, AWLEN=0, WDATA=0xDEADBEEF, WSTRB=0xF, PREADY=1 -> APB write to 0x100 with PWDATA=0xDEADBEEF; BVALID at cycle 4, BRESP=0, BID=AWID.
- Read ARADDR=0x200, ARLEN=3, PRDATA=beat index, RREADY=1 -> PADDR 0x200/0x204/0x208/0x20C; RDATA 0..3; RLAST only on the 4th beat.
- Write burst AWLEN=2 with PSLVERR=1 on beat 1 only -> 3 APB transfers, a single BRESP=2'b10.
- AWVALID and ARVALID both asserted repeatedly from reset -> grants alternate W, R, W, R.
- PREADY held low for 5 cycles in ACCESS, RREADY low for 3 cycles in R_DATA -> PSEL/PENABLE/PADDR stable; RDATA/RVALID stable.
- Assert AXI_ARESET_N low during W_ACCESS -> PSEL, PENABLE, BVALID = 0 immediately; after release, a new write completes normally.

Source files
------------

// File: rtl/axi2apb_bridge_core.sv
// AXI slave to APB3 master bridge: one AXI transaction in flight, each INCR beat becomes one APB transfer.
// Latency (PREADY high): write AW->BVALID 4 cycles, read AR->RVALID 3 cycles; one APB transfer per beat.
// Backpressure: W/R/B held until handshake, APB wait states unbounded; AW/AR ready only while idle.
module axi2apb_bridge_core #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 5
) (
  input  logic                AXI_ACLK,
  input  logic                AXI_ARESET_N,
  input  logic [ID_W-1:0]     AXI_AWID,
  input  logic [ADDR_W-1:0]   AXI_AWADDR,
  input  logic [3:0]          AXI_AWLEN,
  input  logic                AXI_AWVALID,
  output logic                AXI_AWREADY,
  input  logic [DATA_W-1:0]   AXI_WDATA,
  input  logic [DATA_W/8-1:0] AXI_WSTRB,
  input  logic                AXI_WVALID,
  output logic                AXI_WREADY,
  output logic [ID_W-1:0]     AXI_BID,
  output logic [1:0]          AXI_BRESP,
  output logic                AXI_BVALID,
  input  logic                AXI_BREADY,
  input  logic [ID_W-1:0]     AXI_ARID,
  input  logic [ADDR_W-1:0]   AXI_ARADDR,
  input  logic [3:0]          AXI_ARLEN,
  input  logic                AXI_ARVALID,
  output logic                AXI_ARREADY,
  output logic [ID_W-1:0]     AXI_RID,
  output logic [DATA_W-1:0]   AXI_RDATA,
  output logic [1:0]          AXI_RRESP,
  output logic                AXI_RLAST,
  output logic                AXI_RVALID,
  input  logic                AXI_RREADY,
  output logic [ADDR_W-1:0]   PADDR,
  output logic                PWRITE,
  output logic                PSEL,
  output logic                PENABLE,
  output logic [DATA_W-1:0]   PWDATA,
  output logic [DATA_W/8-1:0] PSTRB,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(DATA_W / 8);

  typedef enum logic [2:0] {
    IDLE, W_WAIT, W_SETUP, W_ACCESS, B_RESP, R_SETUP, R_ACCESS, R_DATA
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          len_q, len_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                prio_w_q, prio_w_d;   // 1: write wins a tie
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;
  logic                rlast_q, rlast_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                rvalid_q, rvalid_d;
  logic                grant_w, grant_r;

  // Round-robin arbitration between AW and AR, only offered while idle and out of reset
  always_comb begin
    grant_w = 1'b0;
    grant_r = 1'b0;
    if (AXI_ARESET_N && (state_q == IDLE)) begin
      grant_w = AXI_AWVALID && (!AXI_ARVALID || prio_w_q);
      grant_r = AXI_ARVALID && (!AXI_AWVALID || !prio_w_q);
    end
  end

  // Next-state and next-output computation for the bridge sequencer
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    prio_w_d = prio_w_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;

    case (state_q)
      IDLE: begin
        if (grant_w) begin
          id_d    = AXI_AWID;
          addr_d  = AXI_AWADDR;
          len_d   = AXI_AWLEN;
          cnt_d   = 4'd0;
          err_d   = 1'b0;
          state_d = W_WAIT;
        end else if (grant_r) begin
          id_d    = AXI_ARID;
          addr_d  = AXI_ARADDR;
          len_d   = AXI_ARLEN;
          cnt_d   = 4'd0;
          err_d   = 1'b0;
          pstrb_d = '0;            // reads never drive strobes
          state_d = R_SETUP;
        end
      end
      W_WAIT: begin
        if (AXI_WVALID) begin
          pwdata_d = AXI_WDATA;
          pstrb_d  = AXI_WSTRB;
          state_d  = W_SETUP;
        end
      end
      W_SETUP: state_d = W_ACCESS;
      W_ACCESS: begin
        if (PREADY) begin
          err_d = err_q | PSLVERR;   // error is sticky across the burst
          if (cnt_q == len_q) begin
            state_d = B_RESP;
          end else begin
            cnt_d   = cnt_q + 4'd1;
            addr_d  = addr_q + ADDR_INC;
            state_d = W_WAIT;
          end
        end
      end
      B_RESP: begin
        if (AXI_BREADY) begin
          prio_w_d = 1'b0;
          state_d  = IDLE;
        end
      end
      R_SETUP: state_d = R_ACCESS;
      R_ACCESS: begin
        if (PREADY) begin
          rdata_d = PRDATA;
          rresp_d = PSLVERR ? 2'b10 : 2'b00;
          rlast_d = (cnt_q == len_q);
          state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (AXI_RREADY) begin
          rlast_d = 1'b0;
          if (rlast_q) begin
            prio_w_d = 1'b1;
            state_d  = IDLE;
          end else begin
            cnt_d   = cnt_q + 4'd1;
            addr_d  = addr_q + ADDR_INC;
            state_d = R_SETUP;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered outputs are decoded from the state being entered
    psel_d    = (state_d == W_SETUP) || (state_d == W_ACCESS) ||
                (state_d == R_SETUP) || (state_d == R_ACCESS);
    penable_d = (state_d == W_ACCESS) || (state_d == R_ACCESS);
    pwrite_d  = (state_d == W_SETUP) || (state_d == W_ACCESS);
    bvalid_d  = (state_d == B_RESP);
    bresp_d   = ((state_d == B_RESP) && err_d) ? 2'b10 : 2'b00;
    rvalid_d  = (state_d == R_DATA);
  end

  // State and output registers; reset aborts any transfer without a response
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESET_N) begin
    if (!AXI_ARESET_N) begin
      state_q   <= IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      prio_w_q  <= 1'b1;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      prio_w_q  <= prio_w_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign AXI_AWREADY = grant_w;
  assign AXI_ARREADY = grant_r;
  assign AXI_WREADY  = (state_q == W_WAIT);
  assign AXI_BID     = id_q;
  assign AXI_BRESP   = bresp_q;
  assign AXI_BVALID  = bvalid_q;
  assign AXI_RID     = id_q;
  assign AXI_RDATA   = rdata_q;
  assign AXI_RRESP   = rresp_q;
  assign AXI_RLAST   = rlast_q;
  assign AXI_RVALID  = rvalid_q;
  assign PADDR       = addr_q;
  assign PWRITE      = pwrite_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;

endmodule

// File: tb/tb_axi2apb_bridge_core.sv
// Directed bench for axi2apb_bridge_core: write/read bursts, error merge, arbitration, stalls, reset abort.
// Inputs driven on the falling edge, outputs sampled 1 time unit later.
// APB slave: PRDATA derived from PADDR, PREADY and PSLVERR set per test.
module tb_axi2apb_bridge_core;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [IW-1:0]   awid = '0;
  logic [AW-1:0]   awaddr = '0;
  logic [3:0]      awlen = '0;
  logic            awvalid = 1'b0;
  logic            awready;
  logic [DW-1:0]   wdata = '0;
  logic [DW/8-1:0] wstrb = '0;
  logic            wvalid = 1'b0;
  logic            wready;
  logic [IW-1:0]   bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready = 1'b0;
  logic [IW-1:0]   arid = '0;
  logic [AW-1:0]   araddr = '0;
  logic [3:0]      arlen = '0;
  logic            arvalid = 1'b0;
  logic            arready;
  logic [IW-1:0]   rid;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready = 1'b1;
  logic [AW-1:0]   paddr;
  logic            pwrite, psel, penable;
  logic [DW-1:0]   pwdata;
  logic [DW/8-1:0] pstrb;
  logic [DW-1:0]   prdata;
  logic            pready = 1'b1;
  logic            pslverr;
  logic            err_en = 1'b0;
  logic [AW-1:0]   err_addr = '0;

  int n_checks = 0;
  int n_fail = 0;

  logic [AW-1:0] mon_addr[$];
  logic [DW-1:0] mon_data[$];

  always #5 clk = ~clk;

  // Simple APB slave: read data is the word index above 0x200, error on a chosen address
  assign prdata  = (paddr - 32'h200) >> 2;
  assign pslverr = err_en && (paddr == err_addr);

  axi2apb_bridge_core #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .AXI_ACLK(clk), .AXI_ARESET_N(rst_n),
    .AXI_AWID(awid), .AXI_AWADDR(awaddr), .AXI_AWLEN(awlen), .AXI_AWVALID(awvalid), .AXI_AWREADY(awready),
    .AXI_WDATA(wdata), .AXI_WSTRB(wstrb), .AXI_WVALID(wvalid), .AXI_WREADY(wready),
    .AXI_BID(bid), .AXI_BRESP(bresp), .AXI_BVALID(bvalid), .AXI_BREADY(bready),
    .AXI_ARID(arid), .AXI_ARADDR(araddr), .AXI_ARLEN(arlen), .AXI_ARVALID(arvalid), .AXI_ARREADY(arready),
    .AXI_RID(rid), .AXI_RDATA(rdata), .AXI_RRESP(rresp), .AXI_RLAST(rlast), .AXI_RVALID(rvalid), .AXI_RREADY(rready),
    .PADDR(paddr), .PWRITE(pwrite), .PSEL(psel), .PENABLE(penable), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );

  // Log every completed APB transfer
  always @(posedge clk) begin
    if (rst_n && psel && penable && pready) begin
      mon_addr.push_back(paddr);
      mon_data.push_back(pwdata);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int w);
    case (w)
      0: return awready;
      1: return arready;
      2: return wready;
      3: return bvalid;
      4: return rvalid;
      default: return psel && penable;
    endcase
  endfunction

  // Bounded wait, entered and left at falling edge + 1
  task automatic wait_for(input int w, input string tag);
    int t = 0;
    while (!sig(w) && t < 100) begin
      @(negedge clk); #1;
      t++;
    end
    chk({tag, "_wait"}, {63'd0, sig(w)}, 64'd1);
  endtask

  task automatic clear_mon();
    mon_addr.delete();
    mon_data.delete();
  endtask

  task automatic do_write(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input logic [3:0] len, input logic [1:0] exp_resp);
    clear_mon();
    awid = id; awaddr = addr; awlen = len; awvalid = 1'b1; #1;
    wait_for(0, "wr_aw");
    @(negedge clk); awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wdata = 32'hA000_0000 + b; wstrb = 4'hF; wvalid = 1'b1; #1;
      wait_for(2, "wr_w");
      @(negedge clk); wvalid = 1'b0;
    end
    #1;
    wait_for(3, "wr_b");
    chk("wr_bresp", bresp, exp_resp);
    chk("wr_bid", bid, id);
    @(negedge clk); bready = 1'b1;
    @(negedge clk); bready = 1'b0; #1;
    chk("wr_bvalid_drop", bvalid, 0);
    chk("wr_nxfer", mon_addr.size(), int'(len) + 1);
    for (int b = 0; b < mon_addr.size(); b++) begin
      chk("wr_paddr", mon_addr[b], addr + 32'(4 * b));
      chk("wr_pwdata", mon_data[b], 32'hA000_0000 + b);
    end
  endtask

  task automatic do_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [3:0] len);
    clear_mon();
    rready = 1'b1;
    arid = id; araddr = addr; arlen = len; arvalid = 1'b1; #1;
    wait_for(1, "rd_ar");
    @(negedge clk); arvalid = 1'b0; #1;
    for (int b = 0; b <= int'(len); b++) begin
      wait_for(4, "rd_r");
      chk("rd_rdata", rdata, (addr + 32'(4 * b) - 32'h200) >> 2);
      chk("rd_rlast", rlast, (b == int'(len)) ? 1 : 0);
      chk("rd_rresp", rresp, 0);
      chk("rd_rid", rid, id);
      @(negedge clk); #1;
    end
    chk("rd_nxfer", mon_addr.size(), int'(len) + 1);
    for (int b = 0; b < mon_addr.size(); b++)
      chk("rd_paddr", mon_addr[b], addr + 32'(4 * b));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] held_addr;
    int grants[4];
    int ng;
    int t;

    // Reset state, with a request already pending
    awvalid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_awready", awready, 0);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_wready", wready, 0);
    chk("rst_paddr", paddr, 0);
    awvalid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Single write, exact cycle-by-cycle timing
    clear_mon();
    awid = 5'h0A; awaddr = 32'h100; awlen = 4'd0; awvalid = 1'b1; #1;
    chk("sw_c0_awready", awready, 1);
    @(negedge clk); awvalid = 1'b0;
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1; #1;
    chk("sw_c1_wready", wready, 1);
    chk("sw_c1_psel", psel, 0);
    @(negedge clk); wvalid = 1'b0; #1;
    chk("sw_c2_psel", psel, 1);
    chk("sw_c2_penable", penable, 0);
    chk("sw_c2_pwrite", pwrite, 1);
    chk("sw_c2_paddr", paddr, 32'h100);
    chk("sw_c2_pwdata", pwdata, 32'hDEADBEEF);
    chk("sw_c2_pstrb", pstrb, 4'hF);
    @(negedge clk); #1;
    chk("sw_c3_psel", psel, 1);
    chk("sw_c3_penable", penable, 1);
    chk("sw_c3_bvalid", bvalid, 0);
    @(negedge clk); #1;
    chk("sw_c4_bvalid", bvalid, 1);
    chk("sw_c4_bresp", bresp, 0);
    chk("sw_c4_bid", bid, 5'h0A);
    chk("sw_c4_psel", psel, 0);
    bready = 1'b1;
    @(negedge clk); bready = 1'b0; #1;
    chk("sw_c5_bvalid", bvalid, 0);
    chk("sw_nxfer", mon_addr.size(), 1);

    // Four-beat read burst
    @(negedge clk);
    do_read(5'h03, 32'h200, 4'd3);

    // Three-beat write burst, slave error on the middle beat only
    @(negedge clk);
    err_en = 1'b1; err_addr = 32'h304;
    do_write(5'h11, 32'h300, 4'd2, 2'b10);
    err_en = 1'b0;

    // Read with APB wait states, then R-channel backpressure
    @(negedge clk);
    pready = 1'b0; rready = 1'b0;
    arid = 5'h04; araddr = 32'h208; arlen = 4'd0; arvalid = 1'b1; #1;
    wait_for(1, "st_ar");
    @(negedge clk); arvalid = 1'b0; #1;
    wait_for(5, "st_access");
    held_addr = paddr;
    chk("st_paddr", held_addr, 32'h208);
    chk("st_pstrb_rd", pstrb, 0);
    chk("st_pwrite_rd", pwrite, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("st_psel_hold", psel, 1);
      chk("st_penable_hold", penable, 1);
      chk("st_paddr_hold", paddr, held_addr);
      chk("st_rvalid_early", rvalid, 0);
    end
    pready = 1'b1;
    wait_for(4, "st_r");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("st_rvalid_hold", rvalid, 1);
      chk("st_rdata_hold", rdata, 32'd2);
      chk("st_rlast_hold", rlast, 1);
    end
    rready = 1'b1;
    @(negedge clk); #1;
    chk("st_rvalid_drop", rvalid, 0);

    // Round-robin from a fresh reset with both channels always requesting
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    awid = 5'h01; awaddr = 32'h400; awlen = 4'd0;
    arid = 5'h02; araddr = 32'h200; arlen = 4'd0;
    wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
    bready = 1'b1; rready = 1'b1; pready = 1'b1;
    awvalid = 1'b1; arvalid = 1'b1;
    ng = 0; t = 0;
    while (ng < 4 && t < 200) begin
      #1;
      if (awready || arready) begin
        chk("rr_exclusive", {62'd0, awready, arready}, awready ? 64'd2 : 64'd1);
        grants[ng] = awready ? 0 : 1;
        ng++;
      end
      @(negedge clk);
      t++;
    end
    awvalid = 1'b0; arvalid = 1'b0; wvalid = 1'b0;
    chk("rr_ngrants", ng, 4);
    for (int i = 0; i < 4; i++)
      chk("rr_grant", grants[i], i % 2);
    repeat (10) @(negedge clk);
    bready = 1'b0;

    // Reset asserted during a write access, then a normal write
    pready = 1'b0;
    awid = 5'h06; awaddr = 32'h600; awlen = 4'd0; awvalid = 1'b1; #1;
    wait_for(0, "ra_aw");
    @(negedge clk); awvalid = 1'b0;
    wdata = 32'hCAFE_0001; wstrb = 4'h3; wvalid = 1'b1; #1;
    wait_for(2, "ra_w");
    @(negedge clk); wvalid = 1'b0; #1;
    wait_for(5, "ra_access");
    @(negedge clk);
    rst_n = 1'b0; #1;
    chk("ra_psel", psel, 0);
    chk("ra_penable", penable, 0);
    chk("ra_bvalid", bvalid, 0);
    pready = 1'b1;
    @(negedge clk); #1;
    chk("ra_bvalid_in_rst", bvalid, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    do_write(5'h07, 32'h500, 4'd1, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
